// File: rtl/l2norm_pkg.sv
// Shared types and helpers for the L2-normalisation blocks: FSM states,
// sum-of-squares width derivation and signed saturation. Purely combinational.
package l2norm_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_PRIME,
    ST_DRAIN
  } state_t;

  // Wide enough for VEC_LEN squares of the most negative element.
  function automatic int acc_width(input int data_w, input int vec_len);
    return 2 * data_w + $clog2(vec_len);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/l2norm_row_sequencer_if.sv
// Handshake bundle between the row sequencer and its neighbours: element
// stream in, rsqrt request/response, scaled element stream out.
interface l2norm_row_sequencer_if
  import l2norm_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 16,
  parameter int SCALE_W = 16
);
  localparam int ACC_W = acc_width(DATA_W, VEC_LEN);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     rsq_req_valid;
  logic                     rsq_req_ready;
  logic [ACC_W-1:0]         rsq_operand;
  logic                     rsq_resp_valid;
  logic [SCALE_W-1:0]       rsq_scale;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     busy;

  modport master (
    input  in_valid, in_data, rsq_req_ready, rsq_resp_valid, rsq_scale, out_ready,
    output in_ready, rsq_req_valid, rsq_operand, out_valid, out_data, out_last, busy
  );

  modport slave (
    output in_valid, in_data, rsq_req_ready, rsq_resp_valid, rsq_scale, out_ready,
    input  in_ready, rsq_req_valid, rsq_operand, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/l2norm_scale_sat.sv
// Signed element times unsigned scale, saturated back to DATA_W.
// Combinational, no handshake; the caller registers the result.
module l2norm_scale_sat
  import l2norm_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SCALE_W = 16
) (
  input  logic signed [DATA_W-1:0] i_elem,
  input  logic [SCALE_W-1:0]       i_scale,
  output logic signed [DATA_W-1:0] o_data
);
  localparam int PROD_W = DATA_W + SCALE_W + 1;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [63:0]       w_prod_ext;

  // Extra zero MSB keeps the scale non-negative in the signed product.
  assign w_prod     = i_elem * $signed({1'b0, i_scale});
  assign w_prod_ext = 64'(w_prod);
  assign o_data     = DATA_W'(sat_signed(w_prod_ext, DATA_W));

endmodule

// File: rtl/l2norm_row_sequencer.sv
// Buffers one vector, sends its sum of squares to the rsqrt unit, replays it scaled.
// Request 1 cycle after last accept; output 2 cycles after response; stalls hold out_data.
module l2norm_row_sequencer
  import l2norm_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int VEC_LEN    = 16,
  parameter int SCALE_W    = 16,
  parameter int SCALE_FRAC = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  l2norm_row_sequencer_if.master bus
);
  localparam int ACC_W = acc_width(DATA_W, VEC_LEN);
  localparam int PTR_W = $clog2(VEC_LEN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_LEN - 1);

  if (VEC_LEN < 2 || (VEC_LEN & (VEC_LEN - 1)) != 0 || SCALE_FRAC > SCALE_W) begin : g_bad_param
    $error("l2norm_row_sequencer: illegal parameter combination");
  end

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [DATA_W-1:0] r_buf [VEC_LEN];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [ACC_W-1:0]         r_acc;
  logic [SCALE_W-1:0]       r_scale;
  logic                     r_out_vld;
  logic                     r_out_last;
  logic signed [DATA_W-1:0] r_out_dat;

  logic                       w_in_rdy;
  logic                       w_in_acc;
  logic                       w_last_in;
  logic                       w_out_hs;
  logic                       w_req_vld;
  logic [ACC_W-1:0]           w_operand;
  logic signed [2*DATA_W-1:0] w_sq;
  logic [ACC_W-1:0]           w_acc_nxt;
  logic signed [DATA_W-1:0]   w_scaled;

  assign w_in_rdy  = (r_state == ST_LOAD) && !rst;
  assign w_in_acc  = bus.in_valid && w_in_rdy;
  assign w_last_in = w_in_acc && (r_wr_ptr == LAST_IDX);
  assign w_out_hs  = r_out_vld && bus.out_ready;
  assign w_sq      = bus.in_data * bus.in_data;
  assign w_acc_nxt = r_acc + ACC_W'($unsigned(w_sq));

  // The read pointer is zero whenever PRIME runs, so it also selects element 0.
  l2norm_scale_sat #(
    .DATA_W (DATA_W),
    .SCALE_W(SCALE_W)
  ) u_scale_sat (
    .i_elem (r_buf[r_rd_ptr]),
    .i_scale(r_scale),
    .o_data (w_scaled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_vld   = 1'b0;
    w_operand   = '0;
    case (r_state)
      ST_LOAD: begin
        if (w_last_in) begin
          w_state_nxt = (w_acc_nxt == '0) ? ST_PRIME : ST_REQ;
        end
      end
      ST_REQ: begin
        w_req_vld = 1'b1;
        w_operand = r_acc;
        if (bus.rsq_req_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.rsq_resp_valid) begin
          w_state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_out_hs && r_out_last) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_buf[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_acc      <= '0;
      r_scale    <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_dat  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_acc    <= w_acc_nxt;
            // An all-zero vector skips the rsqrt unit and replays as zeros.
            if (w_last_in && (w_acc_nxt == '0)) begin
              r_scale <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (bus.rsq_resp_valid) begin
            r_scale <= bus.rsq_scale;
          end
        end
        ST_PRIME: begin
          r_out_vld  <= 1'b1;
          r_out_dat  <= w_scaled;
          r_out_last <= 1'b0;
          r_rd_ptr   <= PTR_W'(1);
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (r_out_last) begin
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
              r_out_dat  <= '0;
              r_acc      <= '0;
              r_wr_ptr   <= '0;
              r_rd_ptr   <= '0;
            end else begin
              r_out_dat  <= w_scaled;
              r_out_last <= (r_rd_ptr == LAST_IDX);
              r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready      = w_in_rdy;
  assign bus.rsq_req_valid = w_req_vld;
  assign bus.rsq_operand   = w_operand;
  assign bus.out_valid     = r_out_vld;
  assign bus.out_data      = r_out_dat;
  assign bus.out_last      = r_out_last;
  assign bus.busy          = !((r_state == ST_LOAD) && (r_wr_ptr == '0));

endmodule

// File: tb/tb_l2norm_row_sequencer.sv
// Scoreboard bench for l2norm_row_sequencer with VEC_LEN=4 and a behavioural rsqrt model.
module tb_l2norm_row_sequencer;
  import l2norm_pkg::*;

  localparam int DW = 16;
  localparam int VL = 4;
  localparam int SW = 16;
  localparam int AW = acc_width(DW, VL);

  typedef logic signed [15:0] vec_t [4];
  typedef struct {
    logic signed [15:0] dat;
    logic               last;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2norm_row_sequencer_if #(.DATA_W(DW), .VEC_LEN(VL), .SCALE_W(SW)) bus ();

  l2norm_row_sequencer #(
    .DATA_W(DW), .VEC_LEN(VL), .SCALE_W(SW), .SCALE_FRAC(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  out_t            exp_out[$];
  logic [AW-1:0]   exp_op[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // rsqrt model: optional ready stall, then a one-cycle response after m_delay cycles.
  int          m_stall = 0;
  int          m_delay = 3;
  bit          m_auto  = 1'b1;
  logic [15:0] m_scale = '0;

  initial begin
    bus.rsq_req_ready  = 1'b1;
    bus.rsq_resp_valid = 1'b0;
    bus.rsq_scale      = '0;
    forever begin
      @(negedge clk);
      if (bus.rsq_req_valid && !rst) begin
        if (m_stall > 0) begin
          bus.rsq_req_ready = 1'b0;
          repeat (m_stall) @(negedge clk);
          m_stall = 0;
          bus.rsq_req_ready = 1'b1;
        end
        if (m_auto) begin
          repeat (m_delay) @(negedge clk);
          bus.rsq_scale      = m_scale;
          bus.rsq_resp_valid = 1'b1;
          @(negedge clk);
          bus.rsq_resp_valid = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
    end
  end

  bit rnd_rdy = 1'b0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples just after the falling edge, when all bench inputs are settled.
  bit                 exp_zero = 1'b0;
  int                 acc_cnt = 0;
  int                 last_acc_cyc = -100;
  int                 resp_cyc = -100;
  int                 ir_cyc = -1;
  int                 req_rises = 0;
  bit                 p_req_stall = 1'b0;
  bit                 p_out_stall = 1'b0;
  bit                 p_req_vld = 1'b0;
  bit                 p_out_vld = 1'b0;
  logic [AW-1:0]      p_op;
  logic signed [15:0] p_dat;
  logic               p_last;

  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        acc_cnt     = 0;
        ir_cyc      = -1;
        p_req_stall = 1'b0;
        p_out_stall = 1'b0;
        p_req_vld   = 1'b0;
        p_out_vld   = 1'b0;
      end else begin
        if (cyc == ir_cyc) chk("in_ready_after_last", bus.in_ready, 1);
        if (p_req_stall) begin
          chk("req_hold_valid", bus.rsq_req_valid, 1);
          chk("req_hold_operand", bus.rsq_operand, p_op);
        end
        if (p_out_stall) begin
          chk("out_hold_valid", bus.out_valid, 1);
          chk("out_hold_data", bus.out_data, p_dat);
          chk("out_hold_last", bus.out_last, p_last);
        end
        if (bus.rsq_req_valid && !p_req_vld) begin
          req_rises++;
          chk("req_latency", cyc, last_acc_cyc + 1);
        end
        if (bus.out_valid && !p_out_vld)
          chk("out_latency", cyc, exp_zero ? last_acc_cyc + 2 : resp_cyc + 2);
        if (bus.rsq_resp_valid) resp_cyc = cyc;
        if (bus.in_valid && bus.in_ready) begin
          acc_cnt++;
          if (acc_cnt == VL) begin
            acc_cnt      = 0;
            last_acc_cyc = cyc;
          end
        end
        if (bus.rsq_req_valid && bus.rsq_req_ready) begin
          if (exp_op.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_request: got operand %0d expected no request", bus.rsq_operand);
          end else begin
            chk("operand", bus.rsq_operand, exp_op.pop_front());
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_out.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %0d expected no output", bus.out_data);
          end else begin
            e = exp_out.pop_front();
            chk("out_data", bus.out_data, e.dat);
            chk("out_last", bus.out_last, e.last);
          end
          if (bus.out_last) ir_cyc = cyc + 1;
        end
        p_req_stall = bus.rsq_req_valid && !bus.rsq_req_ready;
        p_op        = bus.rsq_operand;
        p_out_stall = bus.out_valid && !bus.out_ready;
        p_dat       = bus.out_data;
        p_last      = bus.out_last;
        p_req_vld   = bus.rsq_req_valid;
        p_out_vld   = bus.out_valid;
      end
    end
  end

  task automatic send_vec(input vec_t v);
    int n;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      n = 0;
      while (!bus.in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles expected 1");
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_out.size() != 0 || exp_op.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d outputs pending expected 0", exp_out.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input logic [AW-1:0] op, input bit has_op,
                         input vec_t ex);
    out_t e;
    if (has_op) exp_op.push_back(op);
    for (int i = 0; i < 4; i++) begin
      e.dat  = ex[i];
      e.last = (i == 3);
      exp_out.push_back(e);
    end
    exp_zero = !has_op;
    send_vec(v);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  vec_t vin;
  vec_t vexp;
  int   r0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd7;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_req_valid", bus.rsq_req_valid, 0);
    chk("rst_operand", bus.rsq_operand, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    @(negedge clk);

    m_scale = 16'd3277;
    vin  = '{16'sd3, 16'sd4, 16'sd0, 16'sd0};
    vexp = '{16'sd9831, 16'sd13108, 16'sd0, 16'sd0};
    run_vec(vin, AW'(25), 1'b1, vexp);

    m_stall = 5;
    rnd_rdy = 1'b1;
    m_scale = 16'd30;
    vin  = '{16'sd100, -16'sd200, 16'sd300, -16'sd400};
    vexp = '{16'sd3000, -16'sd6000, 16'sd9000, -16'sd12000};
    run_vec(vin, AW'(300000), 1'b1, vexp);
    rnd_rdy = 1'b0;

    r0   = req_rises;
    vin  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    vexp = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    run_vec(vin, AW'(0), 1'b0, vexp);
    chk("zero_no_request", req_rises, r0);

    m_scale = 16'd65535;
    vin  = '{16'sh8000, 16'sd32767, 16'sd0, 16'sd0};
    vexp = '{16'sh8000, 16'sd32767, 16'sd0, 16'sd0};
    run_vec(vin, AW'(2147418113), 1'b1, vexp);

    m_auto   = 1'b0;
    exp_zero = 1'b0;
    exp_op.push_back(AW'(25));
    vin = '{16'sd5, 16'sd0, 16'sd0, 16'sd0};
    send_vec(vin);
    repeat (3) @(negedge clk);
    chk("wait_busy", bus.busy, 1);
    chk("wait_req_done", exp_op.size(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.rsq_scale      = 16'd1000;
    bus.rsq_resp_valid = 1'b1;
    @(negedge clk);
    bus.rsq_resp_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_resp_out_valid", bus.out_valid, 0);
    chk("stray_resp_busy", bus.busy, 0);
    chk("stray_resp_in_ready", bus.in_ready, 1);
    m_auto = 1'b1;

    m_scale = 16'd16384;
    vin  = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
    vexp = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0};
    run_vec(vin, AW'(1), 1'b1, vexp);

    chk("scoreboard_empty", exp_out.size() + exp_op.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
